keccak_absorb_buffer: RTL and testbench

//   Upstream of the pad/absorb stage. Packs a 64-bit word stream (valid/ready) into 1088-bit rate blocks.

---
 rtl/keccak_pkg.sv | 26 ++
 rtl/keccak_byte_mask.sv | 24 ++
 rtl/keccak_absorb_buffer.sv | 141 ++++++++++++++
 tb/tb_keccak_absorb_buffer.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/keccak_pkg.sv
// Shared Keccak rate-block constants, absorb-buffer FSM states and a lane byte-swap helper.
package keccak_pkg;

  localparam int unsigned LANE_W     = 64;
  localparam int unsigned LANE_BYTES = 8;
  localparam int unsigned RATE_BITS  = 1088;
  localparam int unsigned RATE_LANES = 17;
  localparam int unsigned RATE_BYTES = 136;
  localparam int unsigned IDX_W      = 5;

  typedef enum logic [1:0] {
    StFill,
    StHold,
    StPad
  } blk_state_e;

  // Reverse byte order of one lane; byte 0 becomes byte 7.
  function automatic logic [LANE_W-1:0] bswap_lane(input logic [LANE_W-1:0] w);
    logic [LANE_W-1:0] r;
    for (int i = 0; i < int'(LANE_BYTES); i++) begin
      r[8*i +: 8] = w[8*(int'(LANE_BYTES)-1-i) +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/keccak_byte_mask.sv
// Byte-valid mask for one 64-bit lane. Non-last words are fully valid; on a last word only
// the lower s_bytes bytes are kept. Counts above 8 saturate to a full lane.
module keccak_byte_mask
  import keccak_pkg::*;
(
  input  logic [3:0]        s_bytes,
  input  logic              s_last,
  output logic [LANE_W-1:0] mask
);

  logic [3:0] nb;

  // Effective byte count, then one 0xFF per valid byte.
  always_comb begin
    nb   = (!s_last || (s_bytes > 4'd8)) ? 4'd8 : s_bytes;
    mask = '0;
    for (int i = 0; i < int'(LANE_BYTES); i++) begin
      if (4'(i) < nb) begin
        mask[8*i +: 8] = 8'hFF;
      end
    end
  end

endmodule

// File: rtl/keccak_absorb_buffer.sv
// Packs a 64-bit word stream into 1088-bit rate blocks with byte count and last flag, and
// appends an empty padding block when a message ends exactly on a rate boundary.
// Optional build macro: BLKBUF_BSWAP_EN byte-reverses each input word before masking.
module keccak_absorb_buffer
  import keccak_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [LANE_W-1:0]    s_data,
  input  logic                 s_last,
  input  logic [3:0]           s_bytes,
  output logic                 blk_valid,
  input  logic                 blk_ready,
  output logic [RATE_BITS-1:0] blk_data,
  output logic [7:0]           blk_nbytes,
  output logic                 blk_last,
  output logic                 busy
);

  blk_state_e           state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [RATE_BITS-1:0] data_q, data_d;
  logic [7:0]           nbytes_q, nbytes_d;
  logic                 last_q, last_d;
  logic                 exact_q, exact_d;
  logic                 busy_q, busy_d;

  logic [LANE_W-1:0]    mask;
  logic [LANE_W-1:0]    lane_in;
  logic [3:0]           bytes_eff;
  logic                 accept;
  logic                 at_end;
  logic                 blk_done;

  keccak_byte_mask u_byte_mask (
    .s_bytes (s_bytes),
    .s_last  (s_last),
    .mask    (mask)
  );

`ifdef BLKBUF_BSWAP_EN
  assign lane_in = bswap_lane(s_data);
`else
  assign lane_in = s_data;
`endif

  assign accept    = s_valid && s_ready;
  assign at_end    = (idx_q == IDX_W'(RATE_LANES - 1));
  assign bytes_eff = (!s_last || (s_bytes > 4'd8)) ? 4'd8 : s_bytes;
  assign blk_done  = accept && (at_end || s_last);

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StFill;
      idx_q    <= '0;
      data_q   <= '0;
      nbytes_q <= '0;
      last_q   <= 1'b0;
      exact_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      data_q   <= data_d;
      nbytes_q <= nbytes_d;
      last_q   <= last_d;
      exact_q  <= exact_d;
      busy_q   <= busy_d;
    end
  end

  // Next FSM state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StFill: if (blk_done) state_d = StHold;
      StHold: if (blk_ready) state_d = exact_q ? StPad : StFill;
      StPad:  if (blk_ready) state_d = StFill;
      default: state_d = StFill;
    endcase
  end

  // Lane fill, block fields and busy tracking.
  always_comb begin
    idx_d    = idx_q;
    data_d   = data_q;
    nbytes_d = nbytes_q;
    last_d   = last_q;
    exact_d  = exact_q;
    busy_d   = busy_q;
    unique case (state_q)
      StFill: begin
        if (accept) begin
          data_d[LANE_W*int'(idx_q) +: LANE_W] = lane_in & mask;
          busy_d = 1'b1;
          if (at_end || s_last) begin
            idx_d    = '0;
            nbytes_d = {idx_q, 3'b000} + {4'b0000, bytes_eff};
            // A message ending on the rate boundary still needs a padding block after this one.
            exact_d  = s_last && at_end && (bytes_eff == 4'd8);
            last_d   = s_last && !(at_end && (bytes_eff == 4'd8));
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      StHold: begin
        if (blk_ready) begin
          data_d   = '0;
          nbytes_d = '0;
          last_d   = exact_q;
          exact_d  = 1'b0;
          busy_d   = !last_q;
        end
      end
      StPad: begin
        if (blk_ready) begin
          nbytes_d = '0;
          last_d   = 1'b0;
          busy_d   = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // Handshake outputs decoded from state.
  always_comb begin
    s_ready   = (state_q == StFill);
    blk_valid = (state_q != StFill);
  end

  assign blk_data   = data_q;
  assign blk_nbytes = nbytes_q;
  assign blk_last   = last_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_keccak_absorb_buffer.sv
// Directed bench for keccak_absorb_buffer: full, partial, empty, stalled and reset messages.
module tb_keccak_absorb_buffer;

  logic          clk;
  logic          rst_n;
  logic          s_valid;
  logic          s_ready;
  logic [63:0]   s_data;
  logic          s_last;
  logic [3:0]    s_bytes;
  logic          blk_valid;
  logic          blk_ready;
  logic [1087:0] blk_data;
  logic [7:0]    blk_nbytes;
  logic          blk_last;
  logic          busy;

  int checks   = 0;
  int failures = 0;

  keccak_absorb_buffer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .s_last     (s_last),
    .s_bytes    (s_bytes),
    .blk_valid  (blk_valid),
    .blk_ready  (blk_ready),
    .blk_data   (blk_data),
    .blk_nbytes (blk_nbytes),
    .blk_last   (blk_last),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_word(input logic [63:0] d, input logic last, input logic [3:0] nb);
    int n;
    @(negedge clk);
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    s_bytes = nb;
    n = 0;
    while (!s_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("s_ready_timeout", 128'(s_ready), 128'd1);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic wait_blk(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (!blk_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_valid"}, 128'(blk_valid), 128'd1);
  endtask

  task automatic consume();
    @(negedge clk);
    blk_ready = 1'b1;
    @(posedge clk);
    #1;
    blk_ready = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst_n     = 1'b0;
    s_valid   = 1'b0;
    s_data    = '0;
    s_last    = 1'b0;
    s_bytes   = 4'd0;
    blk_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_valid", 128'(blk_valid), 128'd0);
    check("rst_ready", 128'(s_ready), 128'd1);
    check("rst_nbytes", 128'(blk_nbytes), 128'd0);
    check("rst_last", 128'(blk_last), 128'd0);
    check("rst_busy", 128'(busy), 128'd0);
    check("rst_data", 128'(|blk_data), 128'd0);
    rst_n = 1'b1;

    // 1: exactly one rate of data, then the appended padding block.
    for (int i = 1; i <= 17; i++) send_word(64'(i), (i == 17), 4'd8);
    wait_blk("t1");
    check("t1_nbytes", 128'(blk_nbytes), 128'd136);
    check("t1_last", 128'(blk_last), 128'd0);
    check("t1_lane0", 128'(blk_data[63:0]), 128'h1);
    check("t1_lane16", 128'(blk_data[1087:1024]), 128'h11);
    check("t1_busy", 128'(busy), 128'd1);
    check("t1_ready", 128'(s_ready), 128'd0);
    consume();
    check("t1_pad_valid", 128'(blk_valid), 128'd1);
    check("t1_pad_nbytes", 128'(blk_nbytes), 128'd0);
    check("t1_pad_last", 128'(blk_last), 128'd1);
    check("t1_pad_data", 128'(|blk_data), 128'd0);
    check("t1_pad_busy", 128'(busy), 128'd1);
    consume();
    check("t1_idle_valid", 128'(blk_valid), 128'd0);
    check("t1_idle_busy", 128'(busy), 128'd0);

    // 2: three words, last with 5 bytes.
    for (int i = 0; i < 3; i++) send_word(64'hFFFF_FFFF_FFFF_FFFF, (i == 2), 4'd5);
    wait_blk("t2");
    check("t2_nbytes", 128'(blk_nbytes), 128'd21);
    check("t2_last", 128'(blk_last), 128'd1);
    check("t2_lane1", 128'(blk_data[127:64]), 128'hFFFF_FFFF_FFFF_FFFF);
    check("t2_lane2", 128'(blk_data[191:128]), 128'h0000_00FF_FFFF_FFFF);
    check("t2_upper", 128'(|blk_data[1087:192]), 128'd0);
    consume();
    check("t2_done_valid", 128'(blk_valid), 128'd0);
    check("t2_done_busy", 128'(busy), 128'd0);

    // 3: empty message.
    send_word(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 4'd0);
    wait_blk("t3");
    check("t3_nbytes", 128'(blk_nbytes), 128'd0);
    check("t3_last", 128'(blk_last), 128'd1);
    check("t3_data", 128'(|blk_data), 128'd0);
    consume();

    // 4: downstream stall; offered words must not be taken.
    send_word(64'hA1, 1'b0, 4'd8);
    send_word(64'hA2, 1'b1, 4'd8);
    wait_blk("t4");
    s_valid = 1'b1;
    s_data  = 64'hDEAD;
    s_last  = 1'b1;
    s_bytes = 4'd8;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("t4_ready", 128'(s_ready), 128'd0);
      check("t4_nbytes", 128'(blk_nbytes), 128'd16);
      check("t4_lanes", 128'(blk_data[127:0]), {64'hA2, 64'hA1});
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    consume();
    check("t4_done_valid", 128'(blk_valid), 128'd0);
    check("t4_cleared", 128'(|blk_data), 128'd0);

    // 5: reset mid-block discards the partial block.
    for (int i = 0; i < 9; i++) send_word(64'hC0 + 64'(i), 1'b0, 4'd8);
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    check("t5_valid", 128'(blk_valid), 128'd0);
    check("t5_ready", 128'(s_ready), 128'd1);
    check("t5_busy", 128'(busy), 128'd0);
    check("t5_data", 128'(|blk_data), 128'd0);
    check("t5_nbytes", 128'(blk_nbytes), 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    send_word(64'hB1, 1'b0, 4'd8);
    send_word(64'hB2, 1'b1, 4'd8);
    wait_blk("t5b");
    check("t5b_nbytes", 128'(blk_nbytes), 128'd16);
    check("t5b_last", 128'(blk_last), 128'd1);
    check("t5b_lanes", 128'(blk_data[127:0]), {64'hB2, 64'hB1});
    check("t5b_upper", 128'(|blk_data[1087:128]), 128'd0);
    consume();

    // 6: byte order of a single full word; s_bytes above 8 saturates.
    send_word(64'h0102_0304_0506_0708, 1'b1, 4'd12);
    wait_blk("t6");
    check("t6_nbytes", 128'(blk_nbytes), 128'd8);
    check("t6_last", 128'(blk_last), 128'd1);
`ifdef BLKBUF_BSWAP_EN
    check("t6_lane0", 128'(blk_data[63:0]), 128'h0807_0605_0403_0201);
`else
    check("t6_lane0", 128'(blk_data[63:0]), 128'h0102_0304_0506_0708);
`endif
    consume();
    check("t6_done_busy", 128'(busy), 128'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
